// File: rtl/shift_right_seq.sv
// Iterative SRL/SRA unit: start/busy/done handshake, one bit per cycle by default.
// Latency shamt+1 edges to done; define SHIFT_FAST_EN to shift up to 4 bits per cycle.
// Backpressure: start is ignored while busy; synchronous active-high reset aborts silently.
module shift_right_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   out_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic                 sgn_q, sgn_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     out_q, out_d;

    logic [SHAMT_W-1:0]   step;
    logic [WIDTH-1:0]     shifted;

`ifdef SHIFT_FAST_EN
    localparam logic [SHAMT_W-1:0] STEP_MAX = SHAMT_W'(4);

    // Arithmetic shift keeps replicating the operand's original MSB, so multi-bit
    // steps give the same result as repeated single-bit steps.
    always_comb begin
        step    = (cnt_q > STEP_MAX) ? STEP_MAX : cnt_q;
        shifted = sgn_q ? $unsigned($signed(data_q) >>> step) : (data_q >> step);
    end
`else
    always_comb begin
        step    = SHAMT_W'(1);
        shifted = {sgn_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
    end
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        done_d  = 1'b0;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d  = in_data;
                    cnt_d   = shamt;
                    sgn_d   = arith;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    out_d   = data_q;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    data_d = shifted;
                    cnt_d  = cnt_q - step;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign out_data = out_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Scoreboard bench for shift_right_seq: expected results queued at the start edge,
// compared when done pulses; latency, busy and out_data hold are checked alongside.
module tb_shift_right_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] in_data;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] out_data;

    int          n_checks;
    int          n_errors;
    logic [31:0] sb[$];
    logic [31:0] exp_out;
    bit          mon_en;

    shift_right_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .shamt    (shamt),
        .arith    (arith),
        .busy     (busy),
        .done     (done),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic a);
        logic [31:0] r;
        r = d;
        for (int i = 0; i < s; i++) r = {a & d[31], r[31:1]};
        return r;
    endfunction

    function automatic int ref_latency(input int s);
`ifdef SHIFT_FAST_EN
        return (s + 3) / 4 + 1;
`else
        return s + 1;
`endif
    endfunction

    // Scoreboard side: every done pulse must match the oldest queued result,
    // and out_data must hold its last result in all other cycles.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    exp_out = sb.pop_front();
                    check_eq("out_data", out_data, exp_out);
                end
            end else begin
                check_eq("out_hold", out_data, exp_out);
            end
        end
    end

    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                          input bit poke_busy);
        int edges;
        @(posedge clk);
        #1;
        start   = 1'b1;
        in_data = d;
        shamt   = s;
        arith   = a;
        @(posedge clk);
        sb.push_back(ref_shift(d, int'(s), a));
        #1;
        // Inputs are scrambled after acceptance; only latched copies may matter.
        in_data = $urandom;
        shamt   = 5'($urandom);
        arith   = 1'($urandom);
        start   = poke_busy;
        if (poke_busy) in_data = 32'hFFFF_FFFF;
        edges = 0;
        while (!done && edges < 64) begin
            check_eq("busy_during_op", {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
        end
        check_eq("latency", edges, ref_latency(int'(s)));
        check_eq("busy_at_done", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("done_pulse_len", {31'd0, done}, 32'd0);
        check_eq("busy_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic round_trip(input logic [31:0] v);
        run_op(v << 2, 5'd2, 1'b0, 1'b0);
        check_eq("round_trip", out_data, v & 32'h3FFF_FFFF);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_out  = 32'd0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        in_data  = 32'd0;
        shamt    = 5'd0;
        arith    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_out", out_data, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        run_op(32'h8000_0000, 5'd4, 1'b0, 1'b0);
        check_eq("srl_basic", out_data, 32'h0800_0000);
        round_trip(32'hDEAD_BEEF);

        run_op(32'h8000_0000, 5'd4, 1'b1, 1'b0);
        check_eq("sra_basic", out_data, 32'hF800_0000);
        round_trip(32'hC000_0001);

        run_op(32'h1234_5678, 5'd0, 1'b1, 1'b0);
        check_eq("shamt_zero", out_data, 32'h1234_5678);
        round_trip(32'h1234_5678);

        run_op(32'h8000_0001, 5'd31, 1'b1, 1'b0);
        check_eq("sra_max", out_data, 32'hFFFF_FFFF);
        run_op(32'h8000_0001, 5'd31, 1'b0, 1'b0);
        check_eq("srl_max", out_data, 32'h0000_0001);
        round_trip(32'hFFFF_FFFF);

        run_op(32'h0F0F_0000, 5'd8, 1'b0, 1'b1);
        check_eq("start_while_busy", out_data, 32'h000F_0F00);
        round_trip(32'h5A5A_A5A5);

        // Abort an operation two cycles after acceptance.
        @(posedge clk);
        #1;
        start   = 1'b1;
        in_data = 32'hAAAA_5555;
        shamt   = 5'd10;
        arith   = 1'b1;
        @(posedge clk);
        sb.push_back(ref_shift(32'hAAAA_5555, 10, 1'b1));
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        exp_out = 32'd0;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_out", out_data, 32'd0);
        mon_en = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        run_op(32'h8765_4321, 5'd3, 1'b1, 1'b0);
        check_eq("after_abort", out_data, 32'hF0EC_A864);
        round_trip(32'h0000_0003);

        for (int i = 0; i < 8; i++) begin
            run_op($urandom, 5'($urandom), 1'($urandom), 1'b0);
        end

        repeat (2) @(posedge clk);
        check_eq("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
